// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: EX/MEM destination shadows, branch operand
// forwarding selects, load->branch stall, redirect/flush gating and perf counters.
package branch_hazard_pkg;
  localparam logic [1:0] FW_BR_ORIGIN  = 2'd0;
  localparam logic [1:0] FW_BR_EX_ALU  = 2'd1;
  localparam logic [1:0] FW_BR_MEM_ALU = 2'd2;
  localparam logic [1:0] FW_BR_MEM_MEM = 2'd3;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
endpackage

// Per-operand forwarding select; EX has priority over MEM.
module branch_hazard_fwd
  import branch_hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            used,
  input  logic [RA_W-1:0] src,
  input  logic            ex_wreg,
  input  logic [RA_W-1:0] ex_waddr,
  input  logic            ex_load,
  input  logic            mem_wreg,
  input  logic [RA_W-1:0] mem_waddr,
  input  logic            mem_load,
  output logic [1:0]      sel,
  output logic            haz
);
  logic ex_hit, mem_hit;

  always_comb begin
    ex_hit  = used && (src != '0) && ex_wreg  && (ex_waddr  == src);
    mem_hit = used && (src != '0) && mem_wreg && (mem_waddr == src);
    sel     = FW_BR_ORIGIN;
    haz     = 1'b0;
    if (ex_hit) begin
      // load result not available until MEM; wait a cycle on the register file path
      if (ex_load) haz = 1'b1;
      else         sel = FW_BR_EX_ALU;
    end else if (mem_hit) begin
      sel = mem_load ? FW_BR_MEM_MEM : FW_BR_MEM_ALU;
    end
  end
endmodule

module branch_hazard_ctrl
  import branch_hazard_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      inst_ID,
  input  logic             id_valid,
  input  logic             id_wreg,
  input  logic [RA_W-1:0]  id_waddr,
  input  logic             id_is_load,
  input  logic             hold_ext,
  input  logic             is_branch_raw,
  input  logic             is_rst_raw,
  output logic [1:0]       FW_br_A,
  output logic [1:0]       FW_br_B,
  output logic             stall_IF_ID,
  output logic             bubble_ID_EX,
  output logic             is_branch,
  output logic             is_rst_IF_ID,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_stall
);
  localparam int NUM_OPS = 2;
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_LDSTALL = 1'b1;

  typedef struct packed {
    logic            wreg;
    logic [RA_W-1:0] waddr;
    logic            load;
  } shadow_t;

  shadow_t          ex_q, ex_d, mem_q, mem_d;
  logic [0:0]       state_q, state_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_branch_q, cnt_branch_d;
  logic [CNT_W-1:0] cnt_taken_q, cnt_taken_d;
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;

  logic [5:0] opcode, funct;
  logic       is_jr, is_beqne, is_jmp, br_class, hazard;

  logic [NUM_OPS-1:0][RA_W-1:0] op_src;
  logic [NUM_OPS-1:0]           op_used;
  logic [NUM_OPS-1:0][1:0]      op_sel;
  logic [NUM_OPS-1:0]           op_haz;

  always_comb begin
    opcode   = inst_ID[31:26];
    funct    = inst_ID[5:0];
    is_jr    = (opcode == OP_SPECIAL) && (funct == FN_JR);
    is_beqne = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_jmp   = (opcode == OP_J) || (opcode == OP_JAL);
    br_class = is_jr || is_beqne || is_jmp;
  end

  assign op_src[0]  = inst_ID[21 +: RA_W];
  assign op_src[1]  = inst_ID[16 +: RA_W];
  assign op_used[0] = id_valid && (is_jr || is_beqne);
  assign op_used[1] = id_valid && is_beqne;

  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    branch_hazard_fwd #(.RA_W(RA_W)) u_fwd (
      .used      (op_used[g]),
      .src       (op_src[g]),
      .ex_wreg   (ex_q.wreg),
      .ex_waddr  (ex_q.waddr),
      .ex_load   (ex_q.load),
      .mem_wreg  (mem_q.wreg),
      .mem_waddr (mem_q.waddr),
      .mem_load  (mem_q.load),
      .sel       (op_sel[g]),
      .haz       (op_haz[g])
    );
  end

  always_comb begin
    hazard       = id_valid && br_class && (|op_haz);
    FW_br_A      = op_sel[0];
    FW_br_B      = op_sel[1];
    stall_IF_ID  = hazard && !hold_ext;
    bubble_ID_EX = stall_IF_ID;
    is_branch    = is_branch_raw && !stall_IF_ID && !hold_ext;
    is_rst_IF_ID = is_rst_raw && !stall_IF_ID && !hold_ext;
  end

  always_comb begin
    state_d      = state_q;
    err_d        = err_q;
    ex_d         = ex_q;
    mem_d        = mem_q;
    cnt_branch_d = cnt_branch_q;
    cnt_taken_d  = cnt_taken_q;
    cnt_stall_d  = cnt_stall_q;
    if (!hold_ext) begin
      state_d = stall_IF_ID ? ST_LDSTALL : ST_RUN;
      // the stalled load has moved to MEM, so a second stall points at a sequencing bug
      if (state_q == ST_LDSTALL && stall_IF_ID) err_d = 1'b1;
      mem_d = ex_q;
      ex_d  = '0;
      if (id_valid && !bubble_ID_EX)
        ex_d = '{wreg: id_wreg, waddr: id_waddr, load: id_is_load};
      if (id_valid && br_class && !stall_IF_ID) cnt_branch_d = cnt_branch_q + CNT_W'(1);
      if (is_branch)   cnt_taken_d = cnt_taken_q + CNT_W'(1);
      if (stall_IF_ID) cnt_stall_d = cnt_stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      err_q        <= 1'b0;
      ex_q         <= '0;
      mem_q        <= '0;
      cnt_branch_q <= '0;
      cnt_taken_q  <= '0;
      cnt_stall_q  <= '0;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      cnt_branch_q <= cnt_branch_d;
      cnt_taken_q  <= cnt_taken_d;
      cnt_stall_q  <= cnt_stall_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      assert (!(state_q == ST_LDSTALL && stall_IF_ID && !hold_ext))
        else $error("branch_hazard_ctrl: load hazard recurred in LDSTALL");
  end

  assign cnt_branch = cnt_branch_q;
  assign cnt_taken  = cnt_taken_q;
  assign cnt_stall  = cnt_stall_q;

  logic unused_bits;
  assign unused_bits = ^{inst_ID[15:6], err_q};
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed scenarios then randomized traffic, checked against an age-ordered
// writer-history model of the branch hazard rules.
module tb_branch_hazard_ctrl;
  localparam logic [1:0] ORIGIN = 2'd0, EX_ALU = 2'd1, MEM_ALU = 2'd2, MEM_MEM = 2'd3;

  typedef enum int {K_ADD, K_LW, K_BEQ, K_BNE, K_J, K_JAL, K_JR, K_SW} kind_t;
  typedef struct {bit wreg; int waddr; bit load;} wr_t;

  logic        clk, rst;
  logic [31:0] inst_ID;
  logic        id_valid, id_wreg, id_is_load, hold_ext, is_branch_raw, is_rst_raw;
  logic [4:0]  id_waddr;
  logic [1:0]  FW_br_A, FW_br_B;
  logic        stall_IF_ID, bubble_ID_EX, is_branch, is_rst_IF_ID;
  logic [31:0] cnt_branch, cnt_taken, cnt_stall;

  branch_hazard_ctrl #(.RA_W(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst_ID(inst_ID), .id_valid(id_valid), .id_wreg(id_wreg),
    .id_waddr(id_waddr), .id_is_load(id_is_load), .hold_ext(hold_ext),
    .is_branch_raw(is_branch_raw), .is_rst_raw(is_rst_raw), .FW_br_A(FW_br_A),
    .FW_br_B(FW_br_B), .stall_IF_ID(stall_IF_ID), .bubble_ID_EX(bubble_ID_EX),
    .is_branch(is_branch), .is_rst_IF_ID(is_rst_IF_ID), .cnt_branch(cnt_branch),
    .cnt_taken(cnt_taken), .cnt_stall(cnt_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0, n_err = 0;
  // hist[0] = youngest older instruction (EX), hist[1] = next older (MEM)
  wr_t   hist[2];
  int unsigned m_branch, m_taken, m_stall;
  kind_t cur_kind;
  int    cur_rs, cur_rt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(kind_t k, int rs, int rt, int wd);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = wd[4:0];
    case (k)
      K_ADD:   return {6'h00, s, t, d, 5'd0, 6'h20};
      K_LW:    return {6'h23, s, d, 16'h0000};
      K_BEQ:   return {6'h04, s, t, 16'h0004};
      K_BNE:   return {6'h05, s, t, 16'h0004};
      K_J:     return {6'h02, 26'h0000040};
      K_JAL:   return {6'h03, 26'h0000040};
      K_JR:    return {6'h00, s, 15'd0, 6'h08};
      default: return {6'h2b, s, t, 16'h0000};
    endcase
  endfunction

  task automatic set_id(input kind_t k, input int rs, input int rt, input int wd);
    cur_kind = k; cur_rs = rs; cur_rt = rt;
    inst_ID    = enc(k, rs, rt, wd);
    id_valid   = 1'b1;
    id_wreg    = (k == K_ADD || k == K_LW || k == K_JAL);
    id_waddr   = (k == K_JAL) ? 5'd31 : 5'(wd);
    id_is_load = (k == K_LW);
  endtask

  function automatic void ref_operand(input bit used, input int r, output logic [1:0] sel, output bit haz);
    sel = ORIGIN; haz = 1'b0;
    if (!used || r == 0) return;
    for (int age = 0; age < 2; age++) begin
      if (hist[age].wreg && hist[age].waddr == r) begin
        if (age == 0) begin
          if (hist[0].load) haz = 1'b1; else sel = EX_ALU;
        end else begin
          sel = hist[1].load ? MEM_MEM : MEM_ALU;
        end
        return;
      end
    end
  endfunction

  // Compare current outputs with the model, then advance the model to the next cycle.
  task automatic step();
    logic [1:0] ea, eb;
    bit ha, hb, is_br, use_a, use_b, e_stall, e_br, e_rst;
    is_br = cur_kind inside {K_BEQ, K_BNE, K_J, K_JAL, K_JR};
    use_a = id_valid && (cur_kind inside {K_BEQ, K_BNE, K_JR});
    use_b = id_valid && (cur_kind inside {K_BEQ, K_BNE});
    ref_operand(use_a, cur_rs, ea, ha);
    ref_operand(use_b, cur_rt, eb, hb);
    e_stall = id_valid && is_br && (ha || hb) && !hold_ext;
    e_br    = is_branch_raw && !e_stall && !hold_ext;
    e_rst   = is_rst_raw && !e_stall && !hold_ext;
    chk("fw_a", FW_br_A, ea);
    chk("fw_b", FW_br_B, eb);
    chk("stall", stall_IF_ID, e_stall);
    chk("bubble", bubble_ID_EX, e_stall);
    chk("is_branch", is_branch, e_br);
    chk("is_rst", is_rst_IF_ID, e_rst);
    chk("cnt_branch", cnt_branch, m_branch);
    chk("cnt_taken", cnt_taken, m_taken);
    chk("cnt_stall", cnt_stall, m_stall);
    if (rst) begin
      hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
      m_branch = 0; m_taken = 0; m_stall = 0;
    end else if (!hold_ext) begin
      if (id_valid && is_br && !e_stall) m_branch++;
      if (e_br) m_taken++;
      if (e_stall) m_stall++;
      hist[1] = hist[0];
      if (id_valid && !e_stall) hist[0] = '{id_wreg, int'(id_waddr), id_is_load};
      else                      hist[0] = '{0, 0, 0};
    end
    @(negedge clk);
  endtask

  task automatic idle();
    id_valid = 1'b0; id_wreg = 1'b0; id_is_load = 1'b0; id_waddr = '0;
    inst_ID = '0; cur_kind = K_SW; cur_rs = 0; cur_rt = 0;
    hold_ext = 1'b0; is_branch_raw = 1'b0; is_rst_raw = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; #1 step(); rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; idle();
    hist[0] = '{0, 0, 0}; hist[1] = '{0, 0, 0};
    m_branch = 0; m_taken = 0; m_stall = 0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_fw_a", FW_br_A, ORIGIN);
    chk("rst_stall", stall_IF_ID, 1'b0);
    chk("rst_cnt_branch", cnt_branch, 0);
    chk("rst_cnt_stall", cnt_stall, 0);
    step();

    // 1: add $3 in EX, beq $3,$4
    do_reset();
    set_id(K_ADD, 1, 2, 3); #1 step();
    set_id(K_BEQ, 3, 4, 0); is_branch_raw = 1'b1; #1;
    chk("t1_fw_a", FW_br_A, EX_ALU);
    chk("t1_fw_b", FW_br_B, ORIGIN);
    chk("t1_stall", stall_IF_ID, 1'b0);
    step();

    // 2: lw $5 in EX, bne $0,$5 -> one stall, then MEM_MEM
    do_reset();
    set_id(K_LW, 1, 0, 5); #1 step();
    set_id(K_BNE, 0, 5, 0); is_branch_raw = 1'b1; is_rst_raw = 1'b1; #1;
    chk("t2_stall", stall_IF_ID, 1'b1);
    chk("t2_bubble", bubble_ID_EX, 1'b1);
    chk("t2_is_branch_gated", is_branch, 1'b0);
    step(); #1;
    chk("t2_fw_b", FW_br_B, MEM_MEM);
    chk("t2_no_stall", stall_IF_ID, 1'b0);
    chk("t2_is_branch", is_branch, 1'b1);
    chk("t2_cnt_stall", cnt_stall, 1);
    step();

    // 3: lw $2 then add $2, jr $2 -> newest (EX) wins
    do_reset();
    set_id(K_LW, 1, 0, 2); #1 step();
    set_id(K_ADD, 1, 1, 2); #1 step();
    set_id(K_JR, 2, 0, 0); #1;
    chk("t3_fw_a", FW_br_A, EX_ALU);
    chk("t3_stall", stall_IF_ID, 1'b0);
    step();

    // 4: writes to $0, beq $0,$0
    do_reset();
    set_id(K_ADD, 1, 1, 0); #1 step();
    set_id(K_LW, 1, 0, 0); #1 step();
    set_id(K_BEQ, 0, 0, 0); #1;
    chk("t4_fw_a", FW_br_A, ORIGIN);
    chk("t4_fw_b", FW_br_B, ORIGIN);
    chk("t4_stall", stall_IF_ID, 1'b0);
    step();

    // 5: hazard under hold for 3 cycles, then exactly one stall
    do_reset();
    set_id(K_LW, 1, 0, 5); #1 step();
    set_id(K_BEQ, 5, 1, 0); is_branch_raw = 1'b1; hold_ext = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_hold_stall", stall_IF_ID, 1'b0);
      step();
    end
    hold_ext = 1'b0; #1;
    chk("t5_cnt_frozen", cnt_branch, 0);
    chk("t5_stall", stall_IF_ID, 1'b1);
    step(); #1;
    chk("t5_no_stall", stall_IF_ID, 1'b0);
    chk("t5_fw_a", FW_br_A, MEM_MEM);
    chk("t5_cnt_stall", cnt_stall, 1);
    step();

    // 6: rst during LDSTALL
    do_reset();
    set_id(K_LW, 1, 0, 7); #1 step();
    set_id(K_BEQ, 7, 7, 0); #1 step();
    rst = 1'b1; #1 step();
    rst = 1'b0; #1;
    chk("t6_stall", stall_IF_ID, 1'b0);
    chk("t6_fw_a", FW_br_A, ORIGIN);
    chk("t6_cnt_stall", cnt_stall, 0);
    chk("t6_cnt_branch", cnt_branch, 0);
    step();

    // randomized traffic over a small register set so dependences are frequent
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_id(kind_t'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3));
      id_valid      = ($urandom_range(0, 99) < 85);
      hold_ext      = ($urandom_range(0, 99) < 15);
      is_branch_raw = $urandom_range(0, 1);
      is_rst_raw    = $urandom_range(0, 1);
      rst           = ($urandom_range(0, 199) == 0);
      #1 step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
